// File: rtl/vga_pkg.sv
// Shared VGA/text-path definitions used by the text buffer and the renderers.
package vga_pkg;

    // Character codes used by the text path.
    localparam logic [6:0] SPACE  = 7'h20;
    localparam logic [6:0] TXT_LF = 7'h7F;

    // Text grid address widths shared between the buffer and the renderers.
    localparam int TXT_COL_AW = 4;
    localparam int TXT_ROW_AW = 4;

    // Text buffer controller states.
    typedef enum logic [1:0] {
        TXT_IDLE,
        TXT_CLR_ALL,
        TXT_CLR_PG
    } txt_state_t;

    // Page-select width: at least one bit even for a single page.
    function automatic int txt_pg_w(input int pages);
        return (pages > 1) ? $clog2(pages) : 1;
    endfunction

endpackage

// File: rtl/txt_buf_ram.sv
// Simple dual-port character RAM: one synchronous write port and one
// registered, read-first read port.
module txt_buf_ram #(
    parameter int DW    = 7,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // NOTE: the array has no reset; its contents are initialised by the clear sweep, which keeps it mappable onto block RAM.
    logic [DW-1:0] mem [DEPTH];

    // Write port and registered read; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/game_txt_buffer.sv
// Multi-page writable text buffer: cursor-based write port for game logic,
// one-cycle registered read port for the renderer, frame-synchronous page swap.
module game_txt_buffer
    import vga_pkg::*;
#(
    parameter int COL_AW = TXT_COL_AW,
    parameter int ROW_AW = TXT_ROW_AW,
    parameter int ROWS   = 8,
    parameter int CODE_W = 7,
    parameter int PAGES  = 2,
    parameter logic [CODE_W-1:0] CLR_CODE = CODE_W'(SPACE),
    parameter logic [CODE_W-1:0] LF_CODE  = CODE_W'(TXT_LF),
    localparam int PG_W = txt_pg_w(PAGES),
    localparam int XY_W = ROW_AW + COL_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XY_W-1:0]   char_xy,
    output logic [CODE_W-1:0] char_code,
    input  logic              frame_start,
    input  logic [PG_W-1:0]   disp_page_req,
    output logic [PG_W-1:0]   disp_page,
    input  logic [PG_W-1:0]   wr_page,
    input  logic              wr_valid,
    input  logic [CODE_W-1:0] wr_code,
    output logic              wr_ready,
    input  logic              cur_set,
    input  logic [XY_W-1:0]   cur_xy,
    input  logic              clr_req,
    output logic              busy,
    output logic [XY_W-1:0]   cursor
);

    localparam int CELLS = 2 ** XY_W;
    localparam int DEPTH = PAGES * CELLS;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [XY_W-1:0] LAST_CELL = XY_W'(ROWS * (2 ** COL_AW) - 1);
    localparam logic [PG_W-1:0] LAST_PG   = PG_W'(PAGES - 1);

    txt_state_t      state_q, state_d;
    logic [XY_W-1:0] cursor_q, cursor_d;
    logic [XY_W-1:0] cell_q, cell_d;
    logic [PG_W-1:0] sweep_pg_q, sweep_pg_d;
    logic [PG_W-1:0] clr_pg_q, clr_pg_d;
    logic [PG_W-1:0] disp_page_q;
    logic            rd_vld_q;
    logic            oor_q;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [CODE_W-1:0] ram_wdata;
    logic [CODE_W-1:0] ram_rdata;

    // Flat RAM address of a cell within a page.
    function automatic logic [AW-1:0] cell_addr(input logic [PG_W-1:0] pg,
                                                 input logic [XY_W-1:0] xy);
        return AW'(int'(pg) * CELLS + int'(xy));
    endfunction

    function automatic logic page_ok(input logic [PG_W-1:0] pg);
        return int'(pg) < PAGES;
    endfunction

    // Start of the next line, wrapping from the last implemented row to row 0.
    function automatic logic [XY_W-1:0] next_line(input logic [XY_W-1:0] xy);
        logic [ROW_AW-1:0] row;
        row = xy[XY_W-1:COL_AW];
        if (int'(row) == ROWS - 1) begin
            row = '0;
        end else begin
            row = row + 1'b1;
        end
        return {row, {COL_AW{1'b0}}};
    endfunction

    // Cell after xy: next column, or start of the next line past the last column.
    function automatic logic [XY_W-1:0] next_cell(input logic [XY_W-1:0] xy);
        if (xy[COL_AW-1:0] == '1) begin
            return next_line(xy);
        end
        return xy + 1'b1;
    endfunction

    // Cursor load value: rows that are not stored fall back to row 0.
    function automatic logic [XY_W-1:0] clip_row(input logic [XY_W-1:0] xy);
        if (int'(xy[XY_W-1:COL_AW]) >= ROWS) begin
            return {{ROW_AW{1'b0}}, xy[COL_AW-1:0]};
        end
        return xy;
    endfunction

    // Next-state, command decode and RAM write-port selection.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        cursor_d   = cursor_q;
        cell_d     = cell_q;
        sweep_pg_d = sweep_pg_q;
        clr_pg_d   = clr_pg_q;
        ram_we     = 1'b0;
        ram_waddr  = cell_addr(wr_page, cursor_q);
        ram_wdata  = wr_code;
        wr_ready   = 1'b0;
        busy       = 1'b1;

        case (state_q)
            TXT_IDLE: begin
                busy     = 1'b0;
                wr_ready = !clr_req && !cur_set;
                if (clr_req) begin
                    state_d  = TXT_CLR_PG;
                    clr_pg_d = wr_page;
                    cell_d   = '0;
                end else if (cur_set) begin
                    cursor_d = clip_row(cur_xy);
                end else if (wr_valid) begin
                    if (wr_code == LF_CODE) begin
                        cursor_d = next_line(cursor_q);
                    end else begin
                        ram_we   = page_ok(wr_page);
                        cursor_d = next_cell(cursor_q);
                    end
                end
            end

            TXT_CLR_ALL: begin
                ram_we    = 1'b1;
                ram_waddr = cell_addr(sweep_pg_q, cell_q);
                ram_wdata = CLR_CODE;
                if (cell_q == LAST_CELL) begin
                    cell_d = '0;
                    if (sweep_pg_q == LAST_PG) begin
                        state_d    = TXT_IDLE;
                        cursor_d   = '0;
                        sweep_pg_d = '0;
                    end else begin
                        sweep_pg_d = sweep_pg_q + 1'b1;
                    end
                end else begin
                    cell_d = cell_q + 1'b1;
                end
            end

            TXT_CLR_PG: begin
                ram_we    = page_ok(clr_pg_q);
                ram_waddr = cell_addr(clr_pg_q, cell_q);
                ram_wdata = CLR_CODE;
                if (cell_q == LAST_CELL) begin
                    cell_d   = '0;
                    state_d  = TXT_IDLE;
                    cursor_d = '0;
                end else begin
                    cell_d = cell_q + 1'b1;
                end
            end

            default: begin
                state_d = TXT_IDLE;
            end
        endcase
    end

    // State, cursor, sweep counters, display page and read-side flags.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= TXT_CLR_ALL;
            cursor_q    <= '0;
            cell_q      <= '0;
            sweep_pg_q  <= '0;
            clr_pg_q    <= '0;
            disp_page_q <= '0;
            rd_vld_q    <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            cell_q     <= cell_d;
            sweep_pg_q <= sweep_pg_d;
            clr_pg_q   <= clr_pg_d;
            if (frame_start && page_ok(disp_page_req)) begin
                disp_page_q <= disp_page_req;
            end
            rd_vld_q <= 1'b1;
            oor_q    <= int'(char_xy[XY_W-1:COL_AW]) >= ROWS;
        end
    end

    txt_buf_ram #(
        .DW    (CODE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we && !rst),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (cell_addr(disp_page_q, char_xy)),
        .rdata (ram_rdata)
    );

    // Registered read data, zero straight after reset, fill code for unstored rows.
    assign char_code = !rd_vld_q ? '0 : (oor_q ? CLR_CODE : ram_rdata);
    assign disp_page = disp_page_q;
    assign cursor    = cursor_q;

endmodule

// File: tb/tb_game_txt_buffer.sv
// Self-checking bench for game_txt_buffer with a cell-array reference model.
module tb_game_txt_buffer;

    localparam int ROWS  = 8;
    localparam int COLS  = 16;
    localparam int PAGES = 2;
    localparam int CELLS = ROWS * COLS;
    localparam logic [6:0] CLR = 7'h20;
    localparam logic [6:0] LF  = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] char_xy = '0;
    logic [6:0] char_code;
    logic       frame_start = 1'b0;
    logic       disp_page_req = 1'b0;
    logic       disp_page;
    logic       wr_page = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_code = '0;
    logic       wr_ready;
    logic       cur_set = 1'b0;
    logic [7:0] cur_xy = '0;
    logic       clr_req = 1'b0;
    logic       busy;
    logic [7:0] cursor;

    // Three-page instance, used for the out-of-range page request check.
    logic [1:0] disp_page_req3 = '0;
    logic [1:0] disp_page3;
    logic [6:0] char_code3;
    logic       wr_ready3;
    logic       busy3;
    logic [7:0] cursor3;

    logic [6:0] mem_m [PAGES][CELLS];
    int m_row, m_col, m_disp;
    int compared = 0;
    int mismatched = 0;

    game_txt_buffer u_dut (
        .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(char_code),
        .frame_start(frame_start), .disp_page_req(disp_page_req), .disp_page(disp_page),
        .wr_page(wr_page), .wr_valid(wr_valid), .wr_code(wr_code), .wr_ready(wr_ready),
        .cur_set(cur_set), .cur_xy(cur_xy), .clr_req(clr_req), .busy(busy), .cursor(cursor)
    );

    game_txt_buffer #(.PAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .char_xy(char_xy), .char_code(char_code3),
        .frame_start(frame_start), .disp_page_req(disp_page_req3), .disp_page(disp_page3),
        .wr_page(2'd0), .wr_valid(1'b0), .wr_code(7'd0), .wr_ready(wr_ready3),
        .cur_set(1'b0), .cur_xy(8'd0), .clr_req(1'b0), .busy(busy3), .cursor(cursor3)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_cursor();
        return 8'(m_row * COLS + m_col);
    endfunction

    task automatic model_clear_all();
        for (int p = 0; p < PAGES; p++)
            for (int a = 0; a < CELLS; a++) mem_m[p][a] = CLR;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic read_cell(input logic [7:0] xy, output logic [6:0] code);
        char_xy = xy;
        step();
        code = char_code;
    endtask

    task automatic set_disp(input int p);
        disp_page_req = p[0];
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        m_disp = p;
    endtask

    task automatic set_cursor(input logic [7:0] xy);
        cur_xy = xy;
        cur_set = 1'b1;
        step();
        cur_set = 1'b0;
        m_row = (int'(xy[7:4]) >= ROWS) ? 0 : int'(xy[7:4]);
        m_col = int'(xy[3:0]);
    endtask

    task automatic do_write(input int page, input logic [6:0] code);
        wr_page = page[0];
        wr_code = code;
        wr_valid = 1'b1;
        #1;
        compared++;
        if (wr_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL write_ready: got %b want 1", wr_ready);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (code == LF) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else begin
            mem_m[page][m_row * COLS + m_col] = code;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [6:0] got;
        int n;
        rst = 1'b1;
        step();
        compared += 5;
        if (char_code !== 7'd0) begin mismatched++; $display("FAIL rst_char_code: got %h want 00", char_code); end
        if (disp_page !== 1'b0) begin mismatched++; $display("FAIL rst_disp_page: got %h want 0", disp_page); end
        if (cursor !== 8'd0)    begin mismatched++; $display("FAIL rst_cursor: got %h want 00", cursor); end
        if (wr_ready !== 1'b0)  begin mismatched++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        if (busy !== 1'b1)      begin mismatched++; $display("FAIL rst_busy: got %b want 1", busy); end
        rst = 1'b0;
        model_clear_all();
        m_disp = 0;
        wait_idle(n);
        compared += 2;
        if (n != PAGES * CELLS) begin mismatched++; $display("FAIL rst_sweep_len: got %0d want %0d", n, PAGES * CELLS); end
        if (wr_ready !== 1'b1)  begin mismatched++; $display("FAIL rst_ready_after: got %b want 1", wr_ready); end
        for (int p = 0; p < PAGES; p++) begin
            set_disp(p);
            for (int a = 0; a < CELLS; a++) begin
                read_cell(8'(a), got);
                compared++;
                if (got !== mem_m[p][a]) begin
                    mismatched++;
                    $display("FAIL rst_cell p%0d a%02h: got %h want %h", p, a, got, mem_m[p][a]);
                end
            end
        end
    endtask

    task automatic test_seq_wrap();
        logic [6:0] got;
        logic [7:0] addrs [3];
        addrs[0] = 8'h7E; addrs[1] = 8'h7F; addrs[2] = 8'h00;
        set_disp(0);
        set_cursor(8'h7E);
        do_write(0, 7'h11);
        do_write(0, 7'h12);
        do_write(0, 7'h13);
        compared++;
        if (cursor !== m_cursor()) begin mismatched++; $display("FAIL wrap_cursor: got %h want %h", cursor, m_cursor()); end
        for (int i = 0; i < 3; i++) begin
            read_cell(addrs[i], got);
            compared++;
            if (got !== mem_m[0][addrs[i]]) begin
                mismatched++;
                $display("FAIL wrap_cell %02h: got %h want %h", addrs[i], got, mem_m[0][addrs[i]]);
            end
        end
    endtask

    task automatic test_lf_priority();
        logic [6:0] got;
        set_cursor(8'h35);
        do_write(0, LF);
        compared++;
        if (cursor !== m_cursor()) begin mismatched++; $display("FAIL lf_cursor: got %h want %h", cursor, m_cursor()); end
        read_cell(8'h35, got);
        compared++;
        if (got !== mem_m[0][8'h35]) begin mismatched++; $display("FAIL lf_cell35: got %h want %h", got, mem_m[0][8'h35]); end
        // cur_set wins over a simultaneous write.
        cur_xy = 8'h22; cur_set = 1'b1;
        wr_page = 1'b0; wr_code = 7'h55; wr_valid = 1'b1;
        #1;
        compared++;
        if (wr_ready !== 1'b0) begin mismatched++; $display("FAIL prio_ready: got %b want 0", wr_ready); end
        step();
        cur_set = 1'b0; wr_valid = 1'b0;
        m_row = 2; m_col = 2;
        compared++;
        if (cursor !== m_cursor()) begin mismatched++; $display("FAIL prio_cursor: got %h want %h", cursor, m_cursor()); end
        for (int a = 0; a < CELLS; a++) begin
            read_cell(8'(a), got);
            compared++;
            if (got !== mem_m[0][a]) begin mismatched++; $display("FAIL prio_cell %02h: got %h want %h", a, got, mem_m[0][a]); end
        end
        set_cursor(8'hA3);
        compared++;
        if (cursor !== m_cursor()) begin mismatched++; $display("FAIL clip_cursor: got %h want %h", cursor, m_cursor()); end
    endtask

    task automatic test_double_buffer();
        logic [6:0] got;
        int exp3;
        set_disp(0);
        set_cursor(8'h00);
        do_write(1, 7'h2A);
        disp_page_req = 1'b1;
        repeat (3) step();
        compared++;
        if (disp_page !== 1'(m_disp)) begin mismatched++; $display("FAIL db_hold: got %h want %h", disp_page, m_disp); end
        read_cell(8'h00, got);
        compared++;
        if (got !== mem_m[m_disp][0]) begin mismatched++; $display("FAIL db_old_page: got %h want %h", got, mem_m[m_disp][0]); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        m_disp = 1;
        compared++;
        if (disp_page !== 1'(m_disp)) begin mismatched++; $display("FAIL db_swap: got %h want %h", disp_page, m_disp); end
        read_cell(8'h00, got);
        compared++;
        if (got !== mem_m[1][0]) begin mismatched++; $display("FAIL db_new_page: got %h want %h", got, mem_m[1][0]); end
        exp3 = int'(disp_page3);
        for (int r = 2; r <= 3; r++) begin
            disp_page_req3 = 2'(r);
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            if (r < 3) exp3 = r;
            compared++;
            if (disp_page3 !== 2'(exp3)) begin mismatched++; $display("FAIL db_req%0d: got %h want %h", r, disp_page3, exp3); end
        end
    endtask

    task automatic test_page_clear();
        logic [6:0] got;
        int n;
        set_cursor(8'h00);
        for (int a = 0; a < CELLS; a++) do_write(0, 7'($urandom_range(0, 126)));
        set_cursor(8'($urandom_range(0, 255)));
        for (int i = 0; i < 12; i++) do_write(1, 7'($urandom_range(0, 127)));
        wr_page = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        compared++;
        if (wr_ready !== 1'b0) begin mismatched++; $display("FAIL clr_ready: got %b want 0", wr_ready); end
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            clr_req = (n == 40);
            wr_page = (n == 40);
            step();
            n++;
        end
        clr_req = 1'b0;
        wr_page = 1'b0;
        for (int a = 0; a < CELLS; a++) mem_m[0][a] = CLR;
        m_row = 0; m_col = 0;
        compared += 2;
        if (n != CELLS) begin mismatched++; $display("FAIL clr_len: got %0d want %0d", n, CELLS); end
        if (cursor !== m_cursor()) begin mismatched++; $display("FAIL clr_cursor: got %h want %h", cursor, m_cursor()); end
        for (int p = 0; p < PAGES; p++) begin
            set_disp(p);
            for (int a = 0; a < CELLS; a++) begin
                read_cell(8'(a), got);
                compared++;
                if (got !== mem_m[p][a]) begin mismatched++; $display("FAIL clr_cell p%0d a%02h: got %h want %h", p, a, got, mem_m[p][a]); end
            end
        end
        read_cell(8'h90, got);
        compared++;
        if (got !== CLR) begin mismatched++; $display("FAIL oor_read: got %h want %h", got, CLR); end
    endtask

    task automatic test_random();
        logic [6:0] got;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: set_cursor(8'($urandom_range(0, 255)));
                1: do_write(int'($urandom_range(0, 1)), LF);
                default: do_write(int'($urandom_range(0, 1)), 7'($urandom_range(0, 126)));
            endcase
            compared++;
            if (cursor !== m_cursor()) begin mismatched++; $display("FAIL rnd_cursor op%0d: got %h want %h", i, cursor, m_cursor()); end
        end
        for (int p = 0; p < PAGES; p++) begin
            set_disp(p);
            for (int a = 0; a < CELLS; a++) begin
                read_cell(8'(a), got);
                compared++;
                if (got !== mem_m[p][a]) begin mismatched++; $display("FAIL rnd_cell p%0d a%02h: got %h want %h", p, a, got, mem_m[p][a]); end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [6:0] got;
        int n;
        wr_page = 1'b1;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wr_page = 1'b0;
        repeat (49) step();
        disp_page_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear_all();
        m_disp = 0;
        compared += 3;
        if (cursor !== m_cursor()) begin mismatched++; $display("FAIL mid_rst_cursor: got %h want %h", cursor, m_cursor()); end
        if (busy !== 1'b1)         begin mismatched++; $display("FAIL mid_rst_busy: got %b want 1", busy); end
        if (disp_page !== 1'b0)    begin mismatched++; $display("FAIL mid_rst_disp: got %h want 0", disp_page); end
        wait_idle(n);
        compared++;
        if (n != PAGES * CELLS) begin mismatched++; $display("FAIL mid_rst_len: got %0d want %0d", n, PAGES * CELLS); end
        for (int p = 0; p < PAGES; p++) begin
            set_disp(p);
            for (int a = 0; a < CELLS; a++) begin
                read_cell(8'(a), got);
                compared++;
                if (got !== mem_m[p][a]) begin mismatched++; $display("FAIL mid_rst_cell p%0d a%02h: got %h want %h", p, a, got, mem_m[p][a]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq_wrap();
        test_lf_priority();
        test_double_buffer();
        test_page_clear();
        test_random();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
